// File: rtl/bldc_commutation_sequencer_if.sv
// Bus between the motor top level and the commutation sequencer.
// Optional PERIOD signal present only when HALL_PERIOD_EN is defined.
interface bldc_commutation_sequencer_if;
  logic       en;
  logic       clr_fault;
  logic       h1, h2, h3;
  logic [7:0] d;
  logic       a, b, c;
  logic       aa, bb, cc;
  logic       fault;
  logic       dir;
`ifdef HALL_PERIOD_EN
  logic [15:0] period;
`endif

  modport master (
    output en, clr_fault, h1, h2, h3, d,
    input  a, b, c, aa, bb, cc, fault, dir
`ifdef HALL_PERIOD_EN
    , period
`endif
  );

  modport slave (
    input  en, clr_fault, h1, h2, h3, d,
    output a, b, c, aa, bb, cc, fault, dir
`ifdef HALL_PERIOD_EN
    , period
`endif
  );
endinterface

// File: rtl/bldc_commutation_sequencer.sv
// Six-step BLDC commutation sequencer: hall sync/debounce, step validation,
// dead-time insertion and high-side PWM. Define HALL_PERIOD_EN to add the
// commutation period measurement output.
module bldc_commutation_sequencer #(
  parameter int DEBOUNCE = 16,
  parameter int DEADTIME = 50
) (
  input logic                          clk_i,
  input logic                          rst_i,
  bldc_commutation_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_RUN, S_FAULT} state_t;

  // {valid, step index} for a hall code {H3,H2,H1}
  function automatic logic [3:0] code2step(input logic [2:0] code);
    case (code)
      3'b001:  return 4'b1_000;
      3'b101:  return 4'b1_001;
      3'b100:  return 4'b1_010;
      3'b110:  return 4'b1_011;
      3'b010:  return 4'b1_100;
      3'b011:  return 4'b1_101;
      default: return 4'b0_000;
    endcase
  endfunction

  // {low-side CBA, high-side CBA} for a step index
  function automatic logic [5:0] step_gates(input logic [2:0] s);
    case (s)
      3'd0:    return {3'b010, 3'b001};  // A / BB
      3'd1:    return {3'b100, 3'b001};  // A / CC
      3'd2:    return {3'b100, 3'b010};  // B / CC
      3'd3:    return {3'b001, 3'b010};  // B / AA
      3'd4:    return {3'b001, 3'b100};  // C / AA
      3'd5:    return {3'b010, 3'b100};  // C / BB
      default: return 6'b0;
    endcase
  endfunction

  logic [2:0] hs1_q, hs2_q, cand_q, acc_code_q;
  logic [7:0] dbc_q, dbc_d;
  logic       acc_stb_q, hit;

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       dir_q, dir_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic       fault_q;
  logic [2:0] hi_q, hi_d, lo_q, lo_d;
  logic [7:0] cnt_q, cnt_d, duty_q, duty_d;
  logic       pwm_on;
  logic [5:0] gates_d;
  logic       acc_valid, fwd, rev;
  logic [2:0] acc_idx, step_nx, step_pv;
`ifdef HALL_PERIOD_EN
  logic        commit;
  logic [15:0] per_cnt_q, period_q;
`endif

  // Debounce count: restart at 1 on any change, hold once DEBOUNCE is reached
  always_comb begin
    dbc_d = dbc_q;
    if (hs2_q != cand_q)              dbc_d = 8'd1;
    else if (dbc_q != 8'(DEBOUNCE))   dbc_d = dbc_q + 8'd1;
  end

  // Acceptance happens only on the cycle the count first reaches DEBOUNCE
  assign hit = (dbc_d == 8'(DEBOUNCE)) && ((dbc_q != 8'(DEBOUNCE)) || (hs2_q != cand_q));

  // Hall synchronizer, debounce and accepted-code registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs1_q <= '0; hs2_q <= '0; cand_q <= '0; dbc_q <= '0;
      acc_code_q <= '0; acc_stb_q <= 1'b0;
    end else begin
      hs1_q     <= {bus.h3, bus.h2, bus.h1};
      hs2_q     <= hs1_q;
      cand_q    <= hs2_q;
      dbc_q     <= dbc_d;
      acc_stb_q <= hit && (hs2_q != acc_code_q);
      if (hit) acc_code_q <= hs2_q;
    end
  end

  assign {acc_valid, acc_idx} = code2step(acc_code_q);
  assign step_nx = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
  assign step_pv = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
  assign fwd     = acc_idx == step_nx;
  assign rev     = acc_idx == step_pv;

  // PWM period counter; duty only changes at the period boundary
  assign cnt_d  = cnt_q + 8'd1;
  assign duty_d = (cnt_q == 8'hFF) ? bus.d : duty_q;
  assign pwm_on = cnt_d < duty_d;

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dir_d   = dir_q;
    dcnt_d  = dcnt_q;
`ifdef HALL_PERIOD_EN
    commit  = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (bus.en && acc_valid) begin
        state_d = S_DEAD; step_d = acc_idx; dcnt_d = '0;
      end
      S_DEAD, S_RUN: begin
        if (!bus.en) state_d = S_IDLE;
        else if (acc_stb_q) begin
          if (acc_valid && (fwd || rev)) begin
            state_d = S_DEAD; step_d = acc_idx; dir_d = fwd; dcnt_d = '0;
`ifdef HALL_PERIOD_EN
            commit  = 1'b1;
`endif
          end else state_d = S_FAULT;
        end else if (state_q == S_DEAD) begin
          if (dcnt_q == 8'(DEADTIME - 1)) state_d = S_RUN;
          else                            dcnt_d  = dcnt_q + 8'd1;
        end
      end
      S_FAULT: if (bus.clr_fault && acc_valid) begin
        state_d = S_DEAD; step_d = acc_idx; dcnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    gates_d = step_gates(step_d);
    lo_d    = (state_d == S_RUN) ? gates_d[5:3] : 3'b000;
    hi_d    = (state_d == S_RUN && pwm_on) ? gates_d[2:0] : 3'b000;
  end

  // State, step, PWM and gate output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE; step_q <= '0; dir_q <= 1'b1; dcnt_q <= '0;
      fault_q <= 1'b0; hi_q <= '0; lo_q <= '0; cnt_q <= '0; duty_q <= '0;
    end else begin
      state_q <= state_d; step_q <= step_d; dir_q <= dir_d; dcnt_q <= dcnt_d;
      fault_q <= state_d == S_FAULT;
      hi_q    <= hi_d; lo_q <= lo_d;
      cnt_q   <= cnt_d; duty_q <= duty_d;
    end
  end

`ifdef HALL_PERIOD_EN
  // Cycles between legal commutations; restarts at 1 so PERIOD equals the edge gap
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      per_cnt_q <= '0; period_q <= '0;
    end else if (state_d == S_IDLE || state_d == S_FAULT) begin
      per_cnt_q <= '0;
    end else if (commit) begin
      period_q  <= per_cnt_q;
      per_cnt_q <= 16'd1;
    end else if (per_cnt_q != 16'hFFFF) begin
      per_cnt_q <= per_cnt_q + 16'd1;
    end
  end
  assign bus.period = period_q;
`endif

  assign {bus.c, bus.b, bus.a}    = hi_q;
  assign {bus.cc, bus.bb, bus.aa} = lo_q;
  assign bus.fault = fault_q;
  assign bus.dir   = dir_q;
endmodule

// File: tb/tb_bldc_commutation_sequencer.sv
// Scoreboard bench for the BLDC commutation sequencer.
module tb_bldc_commutation_sequencer;
  localparam int DEB = 16;
  localparam int DT  = 50;
  localparam int ACC = 2 + DEB + 1;  // hall change to first gated-off cycle

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bldc_commutation_sequencer_if bus();
  bldc_commutation_sequencer #(.DEBOUNCE(DEB), .DEADTIME(DT)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus));

  wire [2:0] hi_o = {bus.c, bus.b, bus.a};
  wire [2:0] lo_o = {bus.cc, bus.bb, bus.aa};

  typedef struct {logic [2:0] hi; logic [2:0] lo; logic dir;} exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;  // cycles since reset release == DUT PWM count

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic exp_t ref_of(input logic [2:0] code, input logic dir);
    exp_t e;
    e.dir = dir;
    case (code)
      3'b001:  begin e.hi = 3'b001; e.lo = 3'b010; end
      3'b101:  begin e.hi = 3'b001; e.lo = 3'b100; end
      3'b100:  begin e.hi = 3'b010; e.lo = 3'b100; end
      3'b110:  begin e.hi = 3'b010; e.lo = 3'b001; end
      3'b010:  begin e.hi = 3'b100; e.lo = 3'b001; end
      3'b011:  begin e.hi = 3'b100; e.lo = 3'b010; end
      default: begin e.hi = 3'b000; e.lo = 3'b000; end
    endcase
    return e;
  endfunction

  task automatic set_hall(input logic [2:0] code);
    {bus.h3, bus.h2, bus.h1} = code;
  endtask

  task automatic wait_gates_on(output int n, output bit to);
    n = 0;
    do begin @(negedge clk); n++; end while (hi_o == 0 && lo_o == 0 && n < 3000);
    to = (hi_o == 0 && lo_o == 0);
  endtask

  task automatic scan_pair(output logic [2:0] hi, output logic [2:0] lo, output bit bad);
    lo = lo_o; hi = 3'b000; bad = 1'b0;
    repeat (256) begin
      hi |= hi_o;
      if ((hi_o & lo_o) != 0 || lo_o != lo) bad = 1'b1;
      @(negedge clk);
    end
  endtask

  // hall change -> cycles to gates-off, dead length, new pair
  task automatic observe(output int lead, output int dead, output logic [2:0] hi,
                         output logic [2:0] lo, output bit bad, output bit to);
    lead = 0; dead = 0; hi = 0; lo = 0; bad = 0; to = 0;
    while ((hi_o != 0 || lo_o != 0) && lead < 3000) begin @(negedge clk); lead++; end
    if (lead >= 3000) begin to = 1; return; end
    wait_gates_on(dead, to);
    if (to) return;
    scan_pair(hi, lo, bad);
  endtask

  task automatic check_step(input string nm, input logic [2:0] code, input logic dir);
    int lead, dead; logic [2:0] hi, lo; bit bad, to; exp_t e;
    sb.push_back(ref_of(code, dir));
    set_hall(code);
    observe(lead, dead, hi, lo, bad, to);
    e = sb.pop_front();
    n_cmp += 6;
    if (to)            begin n_bad++; $display("FAIL %s timeout: got 1 want 0", nm); end
    if (lead !== ACC)  begin n_bad++; $display("FAIL %s latency: got %0d want %0d", nm, lead, ACC); end
    if (dead !== DT)   begin n_bad++; $display("FAIL %s deadtime: got %0d want %0d", nm, dead, DT); end
    if (lo !== e.lo)   begin n_bad++; $display("FAIL %s low: got %b want %b", nm, lo, e.lo); end
    if (hi !== e.hi)   begin n_bad++; $display("FAIL %s high: got %b want %b", nm, hi, e.hi); end
    if (bus.dir !== e.dir || bad) begin
      n_bad++; $display("FAIL %s dir/overlap: got dir=%b bad=%b want dir=%b bad=0", nm, bus.dir, bad, e.dir);
    end
  endtask

  task automatic test_reset();
    int n, ones; bit to; exp_t e;
    bus.en = 1; bus.clr_fault = 0; bus.d = 8'h60; set_hall(3'b001);
    rst = 1;
    repeat (3) @(negedge clk);
    n_cmp += 3;
    if ({hi_o, lo_o} !== 6'b0) begin n_bad++; $display("FAIL reset gates: got %b want 0", {hi_o, lo_o}); end
    if (bus.fault !== 1'b0)    begin n_bad++; $display("FAIL reset fault: got %b want 0", bus.fault); end
    if (bus.dir !== 1'b1)      begin n_bad++; $display("FAIL reset dir: got %b want 1", bus.dir); end
    sb.push_back(ref_of(3'b001, 1'b1));
    rst = 0;
    wait_gates_on(n, to);
    e = sb.pop_front();
    n_cmp += 2;
    if (to || n !== ACC + DT) begin n_bad++; $display("FAIL startup latency: got %0d want %0d", n, ACC + DT); end
    if (lo_o !== e.lo)        begin n_bad++; $display("FAIL startup low: got %b want %b", lo_o, e.lo); end
    repeat (300) @(negedge clk);
    ones = 0;
    repeat (256) begin ones += int'(bus.a); @(negedge clk); end
    n_cmp++;
    if (ones !== 96) begin n_bad++; $display("FAIL startup duty: got %0d want 96", ones); end
  endtask

  task automatic test_forward();
    logic [2:0] seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    foreach (seq[i]) check_step($sformatf("fwd%0d", i), seq[i], 1'b1);
  endtask

  task automatic test_reverse_glitch();
    int zeros;
    check_step("rev_pre", 3'b101, 1'b1);
    check_step("rev", 3'b001, 1'b0);
    set_hall(3'b100);
    repeat (5) @(negedge clk);
    set_hall(3'b001);
    zeros = 0;
    repeat (300) begin @(negedge clk); if (hi_o == 0 && lo_o == 0) zeros++; end
    n_cmp += 2;
    if (zeros !== 0) begin n_bad++; $display("FAIL glitch offcycles: got %0d want 0", zeros); end
    if (bus.dir !== 1'b0 || bus.fault !== 1'b0) begin
      n_bad++; $display("FAIL glitch state: got dir=%b fault=%b want dir=0 fault=0", bus.dir, bus.fault);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit to;
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_cmp += 2;
    if ({hi_o, lo_o, bus.fault} !== 7'b0) begin n_bad++; $display("FAIL midreset outs: got %b want 0", {hi_o, lo_o, bus.fault}); end
    if (bus.dir !== 1'b1) begin n_bad++; $display("FAIL midreset dir: got %b want 1", bus.dir); end
    wait_gates_on(n, to);
    n_cmp++;
    if (to || n !== ACC + DT) begin n_bad++; $display("FAIL midreset restart: got %0d want %0d", n, ACC + DT); end
  endtask

  task automatic fault_on(input string nm, input logic [2:0] code);
    int n = 0;
    set_hall(code);
    do begin @(negedge clk); n++; end while (!bus.fault && n < 300);
    n_cmp += 2;
    if (n !== ACC) begin n_bad++; $display("FAIL %s fault latency: got %0d want %0d", nm, n, ACC); end
    if ({hi_o, lo_o} !== 6'b0) begin n_bad++; $display("FAIL %s fault gates: got %b want 0", nm, {hi_o, lo_o}); end
  endtask

  task automatic fault_clear(input string nm, input logic [2:0] code);
    int n; bit to, bad; logic [2:0] hi, lo; exp_t e;
    bus.clr_fault = 1;
    @(negedge clk);
    bus.clr_fault = 0;
    sb.push_back(ref_of(code, 1'b0));
    n_cmp++;
    if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL %s clear: got %b want 0", nm, bus.fault); end
    wait_gates_on(n, to);
    scan_pair(hi, lo, bad);
    e = sb.pop_front();
    n_cmp += 3;
    if (to || n !== DT) begin n_bad++; $display("FAIL %s resume: got %0d want %0d", nm, n, DT); end
    if (lo !== e.lo || bad) begin n_bad++; $display("FAIL %s low: got %b bad=%b want %b", nm, lo, bad, e.lo); end
    if (hi !== e.hi) begin n_bad++; $display("FAIL %s high: got %b want %b", nm, hi, e.hi); end
  endtask

  task automatic test_fault();
    fault_on("invalid", 3'b111);
    set_hall(3'b101);
    repeat (40) @(negedge clk);
    n_cmp++;
    if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL fault hold: got %b want 1", bus.fault); end
    fault_clear("clr101", 3'b101);
    fault_on("jump", 3'b110);
    fault_clear("clr110", 3'b110);
  endtask

  task automatic test_pwm();
    int ones, off_at, k;
    bus.d = 8'h00;
    do @(negedge clk); while (cyc % 256 != 0);
    ones = 0;
    repeat (256) begin ones += int'(bus.b); @(negedge clk); end
    n_cmp++;
    if (ones !== 0) begin n_bad++; $display("FAIL duty0: got %0d want 0", ones); end
    do @(negedge clk); while (cyc % 256 != 100);
    bus.d = 8'hFF;
    ones = 0;
    while (cyc % 256 != 0) begin ones += int'(bus.b); @(negedge clk); end
    n_cmp++;
    if (ones !== 0) begin n_bad++; $display("FAIL duty midperiod: got %0d want 0", ones); end
    ones = 0; off_at = -1;
    for (k = 0; k < 256; k++) begin
      ones += int'(bus.b);
      if (!bus.b) off_at = k;
      @(negedge clk);
    end
    n_cmp += 2;
    if (ones !== 255)   begin n_bad++; $display("FAIL duty255: got %0d want 255", ones); end
    if (off_at !== 255) begin n_bad++; $display("FAIL duty255 offslot: got %0d want 255", off_at); end
    bus.d = 8'h60;
  endtask

  task automatic test_enable();
    int n; bit to; exp_t e;
    bus.en = 0;
    @(negedge clk);
    n_cmp++;
    if ({hi_o, lo_o} !== 6'b0) begin n_bad++; $display("FAIL disable: got %b want 0", {hi_o, lo_o}); end
    repeat (10) @(negedge clk);
    sb.push_back(ref_of(3'b110, 1'b0));
    bus.en = 1;
    wait_gates_on(n, to);
    e = sb.pop_front();
    n_cmp += 2;
    if (to || n !== DT + 1) begin n_bad++; $display("FAIL enable resume: got %0d want %0d", n, DT + 1); end
    if (lo_o !== e.lo) begin n_bad++; $display("FAIL enable low: got %b want %b", lo_o, e.lo); end
  endtask

`ifdef HALL_PERIOD_EN
  task automatic test_period();
    set_hall(3'b010);
    repeat (10000) @(negedge clk);
    set_hall(3'b011);
    repeat (200) @(negedge clk);
    n_cmp++;
    if (bus.period !== 16'd10000) begin n_bad++; $display("FAIL period: got %0d want 10000", bus.period); end
    repeat (66000) @(negedge clk);
    set_hall(3'b001);
    repeat (200) @(negedge clk);
    n_cmp++;
    if (bus.period !== 16'hFFFF) begin n_bad++; $display("FAIL period sat: got %0d want 65535", bus.period); end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_reverse_glitch();
    test_reset_mid();
    test_fault();
    test_pwm();
    test_enable();
`ifdef HALL_PERIOD_EN
    test_period();
`endif
    n_cmp++;
    if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard residue: got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bldc_commutation_sequencer.md
# bldc_commutation_sequencer

- Six-step commutation controller for the three-phase BLDC bridge.
- Inputs: the three hall sensors and an 8-bit duty word.
- Hall path: synchronizes and debounces the halls, validates the hall code and its step order, then selects the active phase pair.
- Outputs: six gate drives, with dead time inserted on every commutation and high-side PWM derived from the duty word.
- Placement: directly between the hall inputs / duty register and the gate-driver pins of the top-level motor design.

## Interface
- DEBOUNCE, 16: cycles a synchronized hall code must stay constant before it is accepted (1..255).
- DEADTIME, 50: cycles all six gates are held off on each commutation (1..255).
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  run enable; 0 forces all gates off.
- CLR_FAULT  in  1  single-cycle fault clear request.
- H1, H2, H3  in  1 each  raw hall sensor inputs, asynchronous.
- D  in  8  PWM duty; high-side on-time = D/256 of the period.
- A, B, C  out  1 each  high-side gate drives, phases A/B/C.
- AA, BB, CC  out  1 each  low-side gate drives, phases A/B/C.
- FAULT  out  1  latched fault indication.
- DIR  out  1  1 = forward sequence, 0 = reverse; reflects the last accepted step.
- PERIOD  out  16  cycles between accepted commutations. Present only with HALL_PERIOD_EN.

## Operation
- Hall code is {H3,H2,H1}, passed through a 2-FF synchronizer, then a debounce counter.
  - A new code is accepted after DEBOUNCE consecutive equal samples.
  - Any change of the sampled code restarts the count.
- Step table, forward order (high side PWM'd, low side solid on):
  - 001: A / BB
  - 101: A / CC
  - 100: B / CC
  - 110: B / AA
  - 010: C / AA
  - 011: C / BB
  - Then back to 001.
- Invalid codes are 000 and 111.
- Step validation:
  - Next step in the forward order: DIR=1.
  - Previous step: DIR=0.
  - Any jump of two or more steps is illegal.
- States:
  - IDLE: all gates 0. Go to DEAD when EN=1 and the accepted code is valid.
  - DEAD: all gates 0 while the counter runs DEADTIME cycles, then go to RUN.
  - RUN: drive the table entry for the current step. A newly accepted, different legal code loads the new step and goes to DEAD.
  - FAULT: all gates 0, FAULT=1. Exit to DEAD only when CLR_FAULT=1 and the accepted code is valid; otherwise stay.
- An invalid accepted code or an illegal jump in any state except IDLE goes to FAULT.
- EN=0 in any non-FAULT state goes to IDLE next cycle. FAULT persists regardless of EN.
- A new accepted code during DEAD loads the new step and restarts the dead counter.
- PWM:
  - 8-bit counter, free-running, wraps 255→0.
  - High side is on while cnt < D_latched.
  - D is latched when cnt==255, so D=0 gives 0% and D=255 gives 255/256.
- A high-side and low-side gate of the same phase are never both 1 in any cycle.

## Timing
- Reset values:
  - A, B, C, AA, BB, CC, FAULT = 0; DIR = 1; state IDLE.
  - PWM counter 0, D_latched 0, debounce counter 0, PERIOD 0.
- Hall edge to acceptance: 2 sync cycles + DEBOUNCE cycles.
- Acceptance at cycle t:
  - Gates forced 0 from t+1, since all outputs are registered.
  - New pair driven from t+1+DEADTIME.
- FAULT asserts the cycle after the offending acceptance. Gates are 0 in that same cycle.
- CLR_FAULT at cycle t with a valid code: FAULT=0 at t+1, DEAD entered, gates resume at t+1+DEADTIME.
- A duty change takes effect at the next PWM period boundary, never mid-period.
- RST mid-operation: every output returns to its reset value on the next clock edge. The sequence restarts from IDLE.

## Configuration
- HALL_PERIOD_EN defined:
  - A 16-bit counter counts cycles since the last accepted commutation. It saturates at 65535.
  - On each accepted legal commutation it is copied to PERIOD and then cleared.
  - It is cleared in IDLE and FAULT.
- HALL_PERIOD_EN undefined: the PERIOD port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset with EN=1, halls=001, D=8'h60 → all gates 0 during reset. A PWM'd at 96/256 and BB=1 from 2+16+1+50 cycles after halls become stable.
- Forward rotation 001→101→100→110→010→011→001, each code held 100000 ns → six table pairs in order, DIR=1, 50 all-off cycles at every change, no overlapping phase-pair gates.
- Reverse step 101→001 → DIR=0, A/BB driven after dead time. A 5-cycle glitch to 100 → ignored, no commutation.
- Halls=111, then 101→110 jump → FAULT=1 and gates 0 one cycle after acceptance. CLR_FAULT with 110 → BB... B / AA driven after 50 cycles.
- D stepped from 0 to 255 mid-period → new duty starts at the next cnt wrap. D=0 gives high sides constantly 0, D=255 gives high side low for exactly 1 cycle in 256.
- With HALL_PERIOD_EN, commutations 10000 cycles apart → PERIOD=10000 after the second commutation. A stalled rotor → saturates at 65535.
